phase_pair_decoder: RTL and testbench

- Receiving end of the two-phase clock scheme. Takes the A/B phase pair, where A toggles on the base-clock rising edge and B toggles on the falling edge.
- Samples the pair on a faster system clock. Each pair value maps to a phase index; the block tracks that index and checks that the sequence is legal.
- Produces step strobes, a full-period counter, lock status and error flags. Downstream logic uses these to align to the phase clocks without clocking on them.
- Legal forward sequence of the (A,B) pair: 00 -> 10 -> 11 -> 01 -> 00.

---
 rtl/phase_pair_decoder.sv | 192 +++++++++++++++++++
 tb/tb_phase_pair_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_pair_decoder.sv
// Decodes an A/B two-phase clock pair, sampled on i_clock, into phase index, step strobes,
// lock/stall/error status and a base-period counter. Define PHASE_PAIR_SYNC_EN for input synchronizers.
module phase_pair_decoder #(
  parameter int LOCK_COUNT  = 4,
  parameter int STALL_LIMIT = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_phase_A,
  input  logic                   i_phase_B,
  input  logic                   i_clear_error,
  output logic [1:0]             o_phase,
  output logic                   o_step,
  output logic                   o_locked,
  output logic                   o_error,
  output logic                   o_stalled,
  output logic [COUNT_WIDTH-1:0] o_cycle_count
);

  localparam logic [1:0] ST_UNPRIMED = 2'd0;
  localparam logic [1:0] ST_HUNT     = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [7:0]  LOCK_TGT  = 8'(LOCK_COUNT);
  localparam logic [15:0] STALL_TGT = 16'(STALL_LIMIT);

  logic [1:0] pairIn;

`ifdef PHASE_PAIR_SYNC_EN
  // Priming waits until the first real sample has crossed both synchronizer stages and cur.
  localparam logic [1:0] PRIME_CYCLES = 2'd3;

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {i_phase_A, i_phase_B};
      sync2_q <= sync1_q;
    end
  end

  assign pairIn = sync2_q;
`else
  localparam logic [1:0] PRIME_CYCLES = 2'd1;

  assign pairIn = {i_phase_A, i_phase_B};
`endif

  logic [1:0]             state_q,   state_d;
  logic [1:0]             cur_q;
  logic [1:0]             prev_q,    prev_d;
  logic [1:0]             prime_q;
  logic [1:0]             phase_q,   phase_d;
  logic                   step_q,    step_d;
  logic                   error_q,   error_d;
  logic                   stalled_q, stalled_d;
  logic [7:0]             good_q,    good_d;
  logic [15:0]            stall_q,   stall_d;
  logic [COUNT_WIDTH-1:0] count_q,   count_d;

  logic [1:0] curIdx;
  logic [1:0] prevIdx;
  logic [1:0] delta;
  logic       pairChanged;
  logic       enteringLock;

  // Pair encoding (A,B): 00->0, 10->1, 11->2, 01->3.
  function automatic logic [1:0] phaseIndex(input logic [1:0] pair);
    logic [1:0] idx;
    case (pair)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  assign curIdx      = phaseIndex(cur_q);
  assign prevIdx     = phaseIndex(prev_q);
  assign delta       = curIdx - prevIdx;
  assign pairChanged = (cur_q != prev_q);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    phase_d      = phase_q;
    step_d       = 1'b0;
    error_d      = i_clear_error ? 1'b0 : error_q;
    stalled_d    = stalled_q;
    good_d       = good_q;
    stall_d      = stall_q;
    count_d      = count_q;
    enteringLock = 1'b0;

    case (state_q)
      ST_UNPRIMED: begin
        if (prime_q == PRIME_CYCLES) begin
          prev_d  = cur_q;
          phase_d = curIdx;
          state_d = ST_HUNT;
        end
      end

      ST_HUNT, ST_LOCKED: begin
        prev_d  = cur_q;
        phase_d = curIdx;
        if (pairChanged) begin
          stall_d   = 16'd0;
          stalled_d = 1'b0;
          if (delta == 2'd1) begin
            step_d = 1'b1;
            if (state_q == ST_HUNT) begin
              if (good_q + 8'd1 == LOCK_TGT) begin
                state_d      = ST_LOCKED;
                good_d       = 8'd0;
                enteringLock = 1'b1;
              end else begin
                good_d = good_q + 8'd1;
              end
            end
            // A wrap into phase 0 counts even on the step that just achieved lock.
            if ((state_q == ST_LOCKED || enteringLock) && curIdx == 2'd0) begin
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end else begin
            // Reverse (delta 3) and double change (delta 2) are both errors; a new error beats a clear.
            error_d = 1'b1;
            good_d  = 8'd0;
            state_d = ST_HUNT;
          end
        end else begin
          if (stall_q != STALL_TGT) begin
            stall_d = stall_q + 16'd1;
          end
          if (stall_d == STALL_TGT) begin
            stalled_d = 1'b1;
            good_d    = 8'd0;
            state_d   = ST_HUNT;
          end
        end
      end

      default: begin
        state_d = ST_UNPRIMED;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_UNPRIMED;
      cur_q     <= 2'b00;
      prev_q    <= 2'b00;
      prime_q   <= 2'd0;
      phase_q   <= 2'd0;
      step_q    <= 1'b0;
      error_q   <= 1'b0;
      stalled_q <= 1'b0;
      good_q    <= 8'd0;
      stall_q   <= 16'd0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= pairIn;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      error_q   <= error_d;
      stalled_q <= stalled_d;
      good_q    <= good_d;
      stall_q   <= stall_d;
      count_q   <= count_d;
      if (prime_q != PRIME_CYCLES) begin
        prime_q <= prime_q + 2'd1;
      end
    end
  end

  assign o_phase       = phase_q;
  assign o_step        = step_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_error       = error_q;
  assign o_stalled     = stalled_q;
  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_phase_pair_decoder.sv
// Bench for phase_pair_decoder: per-cycle scoreboard against a pin-level model plus
// hand-derived segment expectations for locking, errors, stall, clear and counter wrap.
module tb_phase_pair_decoder;

  localparam int LOCK_COUNT  = 4;
  localparam int STALL_LIMIT = 64;
  localparam int COUNT_WIDTH = 4;
`ifdef PHASE_PAIR_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [1:0]             phase;
    logic                   step;
    logic                   locked;
    logic                   error;
    logic                   stalled;
    logic [COUNT_WIDTH-1:0] count;
  } exp_t;

  typedef struct {
    logic                   a;
    logic                   b;
    int                     hold;
    logic                   clr;
    logic [1:0]             ePhase;
    logic                   eLocked;
    logic                   eError;
    logic                   eStalled;
    logic [COUNT_WIDTH-1:0] eCount;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   i_reset;
  logic                   i_phase_A;
  logic                   i_phase_B;
  logic                   i_clear_error;
  logic [1:0]             o_phase;
  logic                   o_step;
  logic                   o_locked;
  logic                   o_error;
  logic                   o_stalled;
  logic [COUNT_WIDTH-1:0] o_cycle_count;

  int testsRun    = 0;
  int testsFailed = 0;

  exp_t expQ[$];
  logic clrQ[$];

  // Pin-level reference model state
  int                     mState;
  logic [1:0]             mPrev;
  int                     mGood;
  int                     mStall;
  logic                   mStalled;
  logic                   mError;
  logic [1:0]             mPhase;
  logic [COUNT_WIDTH-1:0] mCount;

  vec_t vecs[24];
  vec_t postVecs[3];

  phase_pair_decoder #(
    .LOCK_COUNT (LOCK_COUNT),
    .STALL_LIMIT(STALL_LIMIT),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_phase_A    (i_phase_A),
    .i_phase_B    (i_phase_B),
    .i_clear_error(i_clear_error),
    .o_phase      (o_phase),
    .o_step       (o_step),
    .o_locked     (o_locked),
    .o_error      (o_error),
    .o_stalled    (o_stalled),
    .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] pairIdx(input logic a, input logic b);
    logic [1:0] r;
    case ({a, b})
      2'b00:   r = 2'd0;
      2'b10:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic vec_t mkVec(input logic a, input logic b, input int hold, input logic clr,
                                 input int ph, input logic l, input logic e, input logic s, input int c);
    vec_t v;
    v.a = a; v.b = b; v.hold = hold; v.clr = clr;
    v.ePhase = 2'(ph); v.eLocked = l; v.eError = e; v.eStalled = s; v.eCount = COUNT_WIDTH'(c);
    return v;
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkValue({tag, ".phase"},   int'(o_phase),       int'(e.phase));
    checkValue({tag, ".step"},    int'(o_step),        int'(e.step));
    checkValue({tag, ".locked"},  int'(o_locked),      int'(e.locked));
    checkValue({tag, ".error"},   int'(o_error),       int'(e.error));
    checkValue({tag, ".stalled"}, int'(o_stalled),     int'(e.stalled));
    checkValue({tag, ".count"},   int'(o_cycle_count), int'(e.count));
  endtask

  task automatic modelReset();
    mState = 0; mPrev = 2'b00; mGood = 0; mStall = 0;
    mStalled = 1'b0; mError = 1'b0; mPhase = 2'd0; mCount = '0;
  endtask

  // Expected outputs once this pin sample (and the clear aligned with it) has been evaluated.
  task automatic modelSample(input logic a, input logic b, input logic clr, output exp_t e);
    logic [1:0] p;
    logic [1:0] d;
    logic       stepNow;
    p = {a, b};
    stepNow = 1'b0;
    if (clr) mError = 1'b0;
    if (mState == 0) begin
      mPrev = p; mPhase = pairIdx(a, b); mState = 1;
    end else if (p != mPrev) begin
      d = pairIdx(a, b) - pairIdx(mPrev[1], mPrev[0]);
      mStall = 0; mStalled = 1'b0;
      if (d == 2'd1) begin
        stepNow = 1'b1;
        if (mState == 1) begin
          mGood++;
          if (mGood == LOCK_COUNT) begin mState = 2; mGood = 0; end
        end
        if (mState == 2 && pairIdx(a, b) == 2'd0) mCount = mCount + 1'b1;
      end else begin
        mError = 1'b1; mGood = 0; mState = 1;
      end
      mPrev = p; mPhase = pairIdx(a, b);
    end else begin
      if (mStall < STALL_LIMIT) mStall++;
      if (mStall == STALL_LIMIT) begin mStalled = 1'b1; mGood = 0; mState = 1; end
    end
    e.phase = mPhase; e.step = stepNow; e.locked = (mState == 2);
    e.error = mError; e.stalled = mStalled; e.count = mCount;
  endtask

  // One sample cycle: clears are delayed so they meet the pin sample they were paired with.
  task automatic applyStimulus(input logic a, input logic b, input logic clr);
    exp_t e;
    i_phase_A = a;
    i_phase_B = b;
    clrQ.push_back(clr);
    if (clrQ.size() > DEPTH) i_clear_error = clrQ.pop_front();
    else i_clear_error = 1'b0;
    modelSample(a, b, clr, e);
    expQ.push_back(e);
    @(posedge clk); #1;
    if (expQ.size() > DEPTH) begin
      e = expQ.pop_front();
      checkOutput(e, "sb");
    end
  endtask

  task automatic runSegment(input vec_t v, input string tag);
    for (int c = 0; c < v.hold; c++) applyStimulus(v.a, v.b, (c == 0) ? v.clr : 1'b0);
    checkValue({tag, ".phase"},   int'(o_phase),       int'(v.ePhase));
    checkValue({tag, ".locked"},  int'(o_locked),      int'(v.eLocked));
    checkValue({tag, ".error"},   int'(o_error),       int'(v.eError));
    checkValue({tag, ".stalled"}, int'(o_stalled),     int'(v.eStalled));
    checkValue({tag, ".count"},   int'(o_cycle_count), int'(v.eCount));
  endtask

  task automatic doReset(input int cycles, input string tag);
    exp_t z;
    z.phase = 2'd0; z.step = 1'b0; z.locked = 1'b0; z.error = 1'b0; z.stalled = 1'b0; z.count = '0;
    i_reset = 1'b1;
    i_phase_A = 1'b0;
    i_phase_B = 1'b0;
    i_clear_error = 1'b0;
    expQ.delete();
    clrQ.delete();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      checkOutput(z, tag);
    end
    i_reset = 1'b0;
    modelReset();
  endtask

  initial begin
    i_reset = 1'b1;
    i_phase_A = 1'b0;
    i_phase_B = 1'b0;
    i_clear_error = 1'b0;

    vecs[0]  = mkVec(0, 0,  4, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(1, 0,  4, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mkVec(1, 1,  4, 0, 2, 0, 0, 0, 0);
    vecs[3]  = mkVec(0, 1,  4, 0, 3, 0, 0, 0, 0);
    vecs[4]  = mkVec(0, 0,  4, 0, 0, 1, 0, 0, 1);
    vecs[5]  = mkVec(1, 0,  4, 0, 1, 1, 0, 0, 1);
    vecs[6]  = mkVec(1, 1,  4, 0, 2, 1, 0, 0, 1);
    vecs[7]  = mkVec(0, 1,  4, 0, 3, 1, 0, 0, 1);
    vecs[8]  = mkVec(0, 0,  4, 0, 0, 1, 0, 0, 2);
    vecs[9]  = mkVec(1, 0,  4, 0, 1, 1, 0, 0, 2);
    vecs[10] = mkVec(0, 1,  4, 0, 3, 0, 1, 0, 2);
    vecs[11] = mkVec(0, 0,  4, 0, 0, 0, 1, 0, 2);
    vecs[12] = mkVec(1, 0,  4, 1, 1, 0, 0, 0, 2);
    vecs[13] = mkVec(1, 1,  4, 0, 2, 0, 0, 0, 2);
    vecs[14] = mkVec(1, 0,  4, 0, 1, 0, 1, 0, 2);
    vecs[15] = mkVec(1, 1,  4, 0, 2, 0, 1, 0, 2);
    vecs[16] = mkVec(0, 1,  4, 0, 3, 0, 1, 0, 2);
    vecs[17] = mkVec(0, 0,  4, 0, 0, 0, 1, 0, 2);
    vecs[18] = mkVec(1, 0,  4, 0, 1, 1, 1, 0, 2);
    vecs[19] = mkVec(1, 1, 70, 0, 2, 0, 1, 1, 2);
    vecs[20] = mkVec(0, 1,  4, 0, 3, 0, 1, 0, 2);
    vecs[21] = mkVec(0, 0,  4, 1, 0, 0, 0, 0, 2);
    vecs[22] = mkVec(1, 1,  4, 1, 2, 0, 1, 0, 2);
    vecs[23] = mkVec(1, 1,  4, 1, 2, 0, 0, 0, 2);

    postVecs[0] = mkVec(0, 0, 4, 0, 0, 0, 0, 0, 0);
    postVecs[1] = mkVec(1, 0, 4, 0, 1, 0, 0, 0, 0);
    postVecs[2] = mkVec(1, 1, 4, 0, 2, 0, 0, 0, 0);

    doReset(3, "reset");

    for (int i = 0; i < 24; i++) runSegment(vecs[i], $sformatf("vec%0d", i));

    // Relock from 11, then 16 locked periods; the counter passes 15 and wraps to 0.
    for (int p = 0; p <= 16; p++) begin
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0);
      if (p > 0) begin
        checkValue($sformatf("wrap%0d.count", p), int'(o_cycle_count), (2 + p) % 16);
        checkValue($sformatf("wrap%0d.locked", p), int'(o_locked), 1);
      end
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 1'b0);
    doReset(2, "midreset");

    for (int i = 0; i < 3; i++) runSegment(postVecs[i], $sformatf("post%0d", i));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
